// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core.
// Used by the main FSM, the ALU decoder and the datapath.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_main_fsm.sv
// Moore main controller of the multicycle RV32I core.
// Drives mux selects, enables and ALUOp one state per cycle.
import riscv_pkg::*;

module mc_main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IllegalInstr,
  output logic [3:0] State
);

  state_t state;

  logic irw, pcu, br, rw, mw, ill;

  // State register with opcode-driven branching out of DECODE/MEMADR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          unique case (op)
            OP_LW,
            OP_SW:   state <= MEMADR;
            OP_R:    state <= EXECR;
            OP_I:    state <= EXECI;
            OP_JAL:  state <= JAL;
            OP_BEQ:  state <= BEQ;
            default: state <= ILLEGAL;
          endcase
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        JAL:      state <= ALUWB;
        BEQ:      state <= FETCH;
        ILLEGAL:  state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Per-state output decode; unlisted signals stay at 0
  always_comb begin
    ALUOp     = ALUOP_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    irw       = 1'b0;
    pcu       = 1'b0;
    br        = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    ill       = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        irw       = 1'b1;
        pcu       = 1'b1;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FN;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FN;
      end
      ALUWB: begin
        rw = 1'b1;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pcu     = 1'b1;
      end
      BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        br      = 1'b1;
      end
      ILLEGAL: begin
        ill = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables drop asynchronously with reset so no partial write escapes
  assign IRWrite      = irw & ~reset;
  assign PCWrite      = (pcu | (br & Zero)) & ~reset;
  assign RegWrite     = rw & ~reset;
  assign MemWrite     = mw & ~reset;
  assign IllegalInstr = ill & ~reset;
  assign State        = state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm.
// Random instruction stream against a per-instruction state-path model.
import riscv_pkg::*;

module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic       Zero = 1'b0;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic       IllegalInstr;
  logic [3:0] State;

  mc_main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IllegalInstr(IllegalInstr), .State(State)
  );

  always #5 clk = ~clk;

  logic [17:0] expq[$];
  logic [17:0] act, want;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  // Expected outputs of one cycle spent in state s
  function automatic logic [17:0] model(input state_t s, input logic z);
    logic [1:0] aop = 2'b00;
    logic [1:0] sa = 2'b00;
    logic [1:0] sb = 2'b00;
    logic [1:0] rs = 2'b00;
    logic adr = 1'b0, irw = 1'b0, pcw = 1'b0;
    logic rw = 1'b0, mw = 1'b0, ill = 1'b0;
    case (s)
      FETCH:    begin sb = 2'b10; rs = 2'b10; irw = 1; pcw = 1; end
      DECODE:   begin sa = 2'b01; sb = 2'b01; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 2'b01; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECR:    begin sa = 2'b10; aop = 2'b10; end
      EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      ALUWB:    rw = 1;
      JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; end
      ILLEGAL:  ill = 1;
      default:  ;
    endcase
    return {4'(s), aop, sa, sb, rs, adr, irw, pcw, rw, mw, ill};
  endfunction

  // Visited states of one instruction, starting at its fetch
  task automatic plan(input logic [6:0] o, output int n,
                      output state_t s[6]);
    for (int i = 0; i < 6; i++) s[i] = FETCH;
    s[1] = DECODE;
    case (o)
      7'b0000011: begin n = 5; s[2] = MEMADR; s[3] = MEMREAD;
                        s[4] = MEMWB; end
      7'b0100011: begin n = 4; s[2] = MEMADR; s[3] = MEMWRITE; end
      7'b0110011: begin n = 4; s[2] = EXECR; s[3] = ALUWB; end
      7'b0010011: begin n = 4; s[2] = EXECI; s[3] = ALUWB; end
      7'b1101111: begin n = 4; s[2] = JAL; s[3] = ALUWB; end
      7'b1100011: begin n = 3; s[2] = BEQ; end
      default:    begin n = 3; s[2] = ILLEGAL; end
    endcase
  endtask

  // Issue one instruction starting in its FETCH cycle; bz<0 leaves Zero random
  task automatic run_instr(input logic [6:0] o, input int bz);
    state_t s[6];
    logic   z[6];
    int     n;
    plan(o, n, s);
    for (int i = 0; i < n; i++) begin
      z[i] = 1'($urandom);
      if (s[i] == BEQ && bz >= 0) z[i] = bz[0];
      expq.push_back(model(s[i], z[i]));
    end
    op = o;
    for (int i = 0; i < n; i++) begin
      Zero = z[i];
      if (i == n - 1) op = 7'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, req);
    end
  endtask

  // Monitor: compare every cycle against the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      act = {State, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
             IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr};
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty got=%h", act);
      end else begin
        want = expq.pop_front();
        if (act !== want) begin
          bad++;
          $display("FAIL cycle t=%0t got=%h want=%h", $time, act, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[8];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011;
    ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1101111; ops[5] = 7'b1100011;
    ops[6] = 7'b0000000; ops[7] = 7'b1111111;

    repeat (3) begin
      @(negedge clk);
      chk("rst_state", 32'(State), 32'(FETCH));
      chk("rst_enables", {IRWrite, PCWrite, RegWrite, MemWrite,
                          IllegalInstr}, 0);
      chk("rst_selects", {ALUSrcB, ResultSrc}, 4'b1010);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("release_fetch", {State, IRWrite, PCWrite, ALUSrcB},
        {4'(FETCH), 4'b1110});

    mon_en = 1'b1;
    run_instr(7'b0000011, -1);
    run_instr(7'b0100011, -1);
    run_instr(7'b1100011, 1);
    run_instr(7'b1100011, 0);
    run_instr(7'b0010011, -1);
    run_instr(7'b1101111, -1);
    run_instr(7'b0110011, -1);
    run_instr(7'b0000000, -1);
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 8));
      if (r == 8) run_instr(7'($urandom), -1);
      else run_instr(ops[r], -1);
    end
    chk("queue_drained", expq.size(), 0);
    mon_en = 1'b0;

    op = 7'b0000011;
    Zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("lw_memread", {State, AdrSrc}, {4'(MEMREAD), 1'b1});
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(State), 32'(FETCH));
    chk("async_enables", {IRWrite, PCWrite, RegWrite, MemWrite,
                          AdrSrc}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_fetch", {State, IRWrite}, {4'(FETCH), 1'b1});
    @(negedge clk);
    chk("no_memwb_1", {State, RegWrite}, {4'(FETCH), 1'b0});
    @(negedge clk);
    chk("no_memwb_2", {State, RegWrite}, {4'(DECODE), 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
